// File: rtl/board_reader.sv
// board_reader -- read-side scanner for the 160x120 (3-bit) game-board RAM.
//
// On a start pulse in IDLE, sweeps every cell in row-major order (x fastest),
// one RAM read per cycle in which grant is high. Each read is forwarded one
// cycle later to the VGA adapter as a pixel write. Optionally tallies cells
// owned by each of four players.
//
// Ports:
//   CLOCK_50        in   system clock (rising edge)
//   resetn          in   async active-low reset
//   start           in   begin a frame scan (sampled only in IDLE)
//   grant           in   RAM port belongs to this block this cycle
//   ram_q[2:0]      in   RAM read data, valid the cycle after the address
//   ram_address     out  {x[7:0], y[6:0]}
//   vga_x/y/colour  out  pixel coordinates and colour
//   vga_plot        out  pixel write strobe
//   busy            out  high outside IDLE
//   done            out  one-cycle pulse at frame end
//   p1..p4_count    out  owned cells per player, last completed frame
//
// Build option: define BOARD_READER_TURF_COUNT_EN to build the territory
// counters; otherwise the count outputs are tied to zero.

module board_reader #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
    input  logic        grant,
    input  logic [2:0]  ram_q,
    output logic [14:0] ram_address,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        done,
    output logic [14:0] p1_count,
    output logic [14:0] p2_count,
    output logic [14:0] p3_count,
    output logic [14:0] p4_count
);

    localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t     state, state_nxt;
    logic [7:0] x;
    logic [6:0] y;
    logic       issue;
    logic       last_cell;

    // Plot pipeline stage: one cycle behind the issued read.
    logic       plot_q;
    logic [7:0] px;
    logic [6:0] py;
    logic [2:0] col_q;

    assign issue     = (state == S_SCAN) && grant;
    assign last_cell = (x == X_LAST) && (y == Y_LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_SCAN;
            end
            S_SCAN:  if (issue && last_cell) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- scan counter ----------------
    // The address is the counter itself, so it naturally holds while grant is low.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            x <= '0;
            y <= '0;
        end else if (state == S_IDLE && start) begin
            x <= '0;
            y <= '0;
        end else if (issue) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

    assign ram_address = {x, y};

    // ---------------- plot pipeline ----------------
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            plot_q <= 1'b0;
            px     <= '0;
            py     <= '0;
            col_q  <= '0;
        end else begin
            plot_q <= issue;
            if (issue) begin
                px <= x;
                py <= y;
            end
            if (plot_q) col_q <= ram_q;
        end
    end

    // RAM data arrives in the plot cycle itself, so colour passes straight
    // through while plotting and holds the last plotted value otherwise.
    assign vga_plot   = plot_q;
    assign vga_x      = px;
    assign vga_y      = py;
    assign vga_colour = plot_q ? ram_q : col_q;

    // ---------------- territory counters ----------------
`ifdef BOARD_READER_TURF_COUNT_EN
    localparam logic [3:0][2:0] OWN_CODE = {3'b110, 3'b100, 3'b010, 3'b001};

    logic [3:0][14:0] run_cnt;
    logic [3:0][14:0] out_cnt;
    logic [3:0]       hit;

    always_comb begin
        hit = '0;
        for (int p = 0; p < 4; p++)
            hit[p] = plot_q && (ram_q == OWN_CODE[p]);
    end

    // The last cell is plotted during DRAIN, so its hit is folded into the
    // published value on the same edge that clears the running count.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_cnt <= '0;
            out_cnt <= '0;
        end else if (state == S_DRAIN) begin
            for (int p = 0; p < 4; p++)
                out_cnt[p] <= run_cnt[p] + 15'(hit[p]);
            run_cnt <= '0;
        end else begin
            for (int p = 0; p < 4; p++)
                if (hit[p]) run_cnt[p] <= run_cnt[p] + 15'd1;
        end
    end

    assign p1_count = out_cnt[0];
    assign p2_count = out_cnt[1];
    assign p3_count = out_cnt[2];
    assign p4_count = out_cnt[3];
`else
    assign p1_count = '0;
    assign p2_count = '0;
    assign p3_count = '0;
    assign p4_count = '0;
`endif

endmodule

// File: doc/board_reader.md
# board_reader

Read-side scanner for the 160x120x3 game-board RAM. On each `start` pulse it sweeps every board cell, one RAM read per granted cycle. It streams each cell to the VGA adapter as a (x, y, colour, plot) pixel write and tallies per-player territory. It sits beside the per-tick board update engine and shares the RAM port with it through a `grant` signal owned by the top level.

## Interface
- `WIDTH`, 160, cells per row; x range 0..WIDTH-1
- `HEIGHT`, 120, rows; y range 0..HEIGHT-1
- `CLOCK_50`  in  1  system clock, all logic on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a frame scan; sampled only in IDLE
- `grant`  in  1  RAM port owned by this block this cycle
- `ram_q`  in  3  RAM read data; valid the cycle after its address is presented
- `ram_address`  out  15  {x[7:0], y[6:0]} read address
- `vga_x`  out  8  pixel x
- `vga_y`  out  7  pixel y
- `vga_colour`  out  3  pixel colour (raw RAM data)
- `vga_plot`  out  1  pixel write strobe
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at frame end
- `p1_count`, `p2_count`, `p3_count`, `p4_count`  out  15 each  cells owned per player, last completed frame

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN when `start`=1. The scan counter is set to (0,0).
- SCAN, `grant`=1:
  - Issue a read. `ram_address`={x,y}.
  - Advance x. When x wraps WIDTH-1 -> 0, y increments.
  - Row-major order, x fastest.
- SCAN, `grant`=0:
  - No read is issued and the counter holds.
  - `ram_address` holds its value.
- Issuing cell (WIDTH-1, HEIGHT-1) moves SCAN -> DRAIN. DRAIN -> DONE unconditionally. DONE -> IDLE unconditionally.
- Plot pipeline: a read issued in cycle k causes the following in cycle k+1:
  - `vga_plot`=1
  - `vga_x`/`vga_y` = coordinates issued in cycle k
  - `vga_colour`=`ram_q`
- `vga_plot`=0 in every cycle not preceded by an issued read. `vga_x`/`vga_y`/`vga_colour` hold their last values.
- Colour ownership codes:
  - 001 = P1, 010 = P2, 100 = P3, 110 = P4
  - 111 = crash, 000 = empty
  - All other codes are unowned.
- Running counters increment on each plotted owned cell. Crash, empty and unowned cells do not count.
- At the DRAIN->DONE edge, running counters are copied to `pN_count` and cleared.
- `start` outside IDLE is ignored, with no restart and no queueing.
- Reset, including mid-frame: state IDLE. Every output goes to 0: `ram_address`, `vga_*`, `busy`, `done`, all counts. Running counters go to 0.

## Timing
- `start` sampled at edge E0: SCAN from cycle 1. With `grant` held 1:
  - reads issued in cycles 1..19200
  - last plot in cycle 19201 (DRAIN)
  - `done`=1 and new counts visible in cycle 19202 (DONE)
  - IDLE in cycle 19203
- Each `grant`=0 cycle in SCAN delays every later event by exactly one cycle.
- Back-to-back frames: `start` high continuously gives a new SCAN starting in cycle 19204.
- Counts are stable from DONE until the next DONE. They do not change during a scan.
- Arithmetic: x is 8 bits, y is 7 bits, counters are 15 bits. Max count 19200, so there is no overflow.

## Configuration
- `BOARD_READER_TURF_COUNT_EN` defined:
  - Running and output per-player counters are built, as described above.
- Not defined:
  - No counters are built.
  - `p1_count`..`p4_count` are tied to 0.
  - Scan, plot and `done` timing are unchanged.

## Test plan
- RAM preloaded with all 000, `grant`=1, pulse `start`:
  - exactly 19200 plots, in row-major order
  - first plot is (0,0) in cycle 2; last is (159,119) in cycle 19201
  - `done` in cycle 19202; all counts 0
- RAM with (5,3)=001, (6,3)=010, 10 cells=100, 7 cells=110, (0,0)=111, one cell=011:
  - plot at (5,3) carries colour 001
  - counts after `done` are P1=1, P2=1, P3=10, P4=7
- `grant` low every other SCAN cycle:
  - plot sequence identical to the first scenario
  - `done` in cycle 38401
  - `ram_address` is constant during each low cycle
- `start` pulsed again at cycle 500 of a scan:
  - ignored; single `done` in cycle 19202
- `resetn` asserted at cycle 1000, released 3 cycles later:
  - `busy`, `vga_plot` and counts go to 0 immediately
  - a new `start` gives a clean full frame
- Macro undefined, rerun the second scenario:
  - identical plots and `done` cycle
  - all counts 0
